jbi_min_rq_hdr_fifo: RTL and testbench

- Parametrised, flop-based request header queue for the JBI min request path.
- Successor to the fixed 16x65 register-file header buffer, with configurable width and depth.
- Holds complete FIFO control internally: pointers, occupancy, full/almost-full/empty, read-valid handshake, hold/freeze, and error flags.
- Sits between the min write-data/header assembly logic and the request issue logic, all in the JBUS clock domain.

---
 rtl/jbi_min_rq_hdr_fifo_pkg.sv | 16 +
 rtl/jbi_min_rq_hdr_fifo_mem.sv | 26 ++
 rtl/jbi_min_rq_hdr_fifo.sv | 124 ++++++++++++
 tb/tb_jbi_min_rq_hdr_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jbi_min_rq_hdr_fifo_pkg.sv
// Shared defaults for the JBI min request header queue and the pointer-width helper.
package jbi_min_rq_hdr_fifo_pkg;

    localparam int JBI_RHQ_WIDTH = 64;
    localparam int JBI_RHQ_DEPTH = 16;
    localparam int JBI_RHQ_AFULL = 14;

    // Smallest n with 2**n >= v; never below 1 so a pointer always has a bit.
    function automatic int jbi_clog2(input int v);
        int n;
        n = 1;
        while ((1 << n) < v) n++;
        return n;
    endfunction

endpackage

// File: rtl/jbi_min_rq_hdr_fifo_mem.sv
// Header storage: DEPTH x WIDTH flop array, one synchronous write port, one combinational read port.
module jbi_min_rq_hdr_fifo_mem
    import jbi_min_rq_hdr_fifo_pkg::*;
#(
    parameter int WIDTH = JBI_RHQ_WIDTH,
    parameter int DEPTH = JBI_RHQ_DEPTH,
    parameter int AW    = jbi_clog2(JBI_RHQ_DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Storage is intentionally not reset; only control state is.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jbi_min_rq_hdr_fifo.sv
// JBI min request header FIFO: pointers, occupancy, flags, registered read port and error pulses.
// Optional per-entry even parity is enabled by defining JBI_MIN_RQ_HDR_FIFO_PAR_EN.
module jbi_min_rq_hdr_fifo
    import jbi_min_rq_hdr_fifo_pkg::*;
#(
    parameter  int WIDTH        = JBI_RHQ_WIDTH,
    parameter  int DEPTH        = JBI_RHQ_DEPTH,
    parameter  int AFULL_THRESH = JBI_RHQ_AFULL,
    localparam int AW           = jbi_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             afull,
    input  logic             rd_en,
    input  logic             hold,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld,
    output logic             empty,
    output logic [AW:0]      level,
    output logic             ovf_err,
    output logic             udf_err
`ifdef JBI_MIN_RQ_HDR_FIFO_PAR_EN
    ,
    output logic             par_err
`endif
);

`ifdef JBI_MIN_RQ_HDR_FIFO_PAR_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    localparam logic [AW:0]   LVL_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_AFULL = (AW+1)'(AFULL_THRESH);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push_acc;
    logic          pop_acc;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign full  = (level == LVL_DEPTH);
    assign empty = (level == '0);
    assign afull = (level >= LVL_AFULL);

    // Flags come from the registered level, so same-cycle push/pop never bypass.
    assign push_acc = wr_en & ~full;
    assign pop_acc  = rd_en & ~empty & ~hold;

`ifdef JBI_MIN_RQ_HDR_FIFO_PAR_EN
    assign wr_entry = {^wr_data, wr_data};
`else
    assign wr_entry = wr_data;
`endif

    jbi_min_rq_hdr_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_acc),
        .wr_addr (wptr),
        .wr_data (wr_entry),
        .rd_addr (rptr),
        .rd_data (rd_entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_acc) wptr <= ptr_inc(wptr);
            if (pop_acc)  rptr <= ptr_inc(rptr);
            if (push_acc && !pop_acc)      level <= level + (AW+1)'(1);
            else if (pop_acc && !push_acc) level <= level - (AW+1)'(1);
        end
    end

    // hold freezes the whole read register, valid and parity status included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
`ifdef JBI_MIN_RQ_HDR_FIFO_PAR_EN
            par_err <= 1'b0;
`endif
        end else if (pop_acc) begin
            rd_data <= rd_entry[WIDTH-1:0];
            rd_vld  <= 1'b1;
`ifdef JBI_MIN_RQ_HDR_FIFO_PAR_EN
            par_err <= ^rd_entry;
`endif
        end else if (!hold) begin
            rd_vld  <= 1'b0;
`ifdef JBI_MIN_RQ_HDR_FIFO_PAR_EN
            par_err <= 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            ovf_err <= wr_en & full;
            udf_err <= rd_en & empty & ~hold;
        end
    end

endmodule

// File: tb/tb_jbi_min_rq_hdr_fifo.sv
// Self-checking bench: a DEPTH=16 and a DEPTH=5 instance driven in lockstep and
// compared each cycle against queue-based reference models.
module tb_jbi_min_rq_hdr_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        rd_en;
    logic        hold;

    logic        full, afull, rd_vld, empty, ovf_err, udf_err;
    logic [63:0] rd_data;
    logic [4:0]  level;
    logic        full5, afull5, rd_vld5, empty5, ovf_err5, udf_err5;
    logic [63:0] rd_data5;
    logic [3:0]  level5;
`ifdef JBI_MIN_RQ_HDR_FIFO_PAR_EN
    logic        par_err, par_err5;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: one FIFO queue plus expected registered outputs per instance.
    logic [63:0] q16[$];
    logic [63:0] q5[$];
    logic        exp_vld[2];
    logic [63:0] exp_data[2];
    logic        exp_ovf[2];
    logic        exp_udf[2];

    localparam int DEP[2]    = '{16, 5};
    localparam int THRESH[2] = '{14, 4};

    typedef struct {
        logic        we;
        logic [63:0] wd;
        logic        re;
        logic        ho;
        logic        ev;
        logic [63:0] ed;
        int          el;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    jbi_min_rq_hdr_fifo dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .afull   (afull),
        .rd_en   (rd_en),
        .hold    (hold),
        .rd_data (rd_data),
        .rd_vld  (rd_vld),
        .empty   (empty),
        .level   (level),
        .ovf_err (ovf_err),
        .udf_err (udf_err)
`ifdef JBI_MIN_RQ_HDR_FIFO_PAR_EN
        ,
        .par_err (par_err)
`endif
    );

    jbi_min_rq_hdr_fifo #(
        .WIDTH        (64),
        .DEPTH        (5),
        .AFULL_THRESH (4)
    ) dut5 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full5),
        .afull   (afull5),
        .rd_en   (rd_en),
        .hold    (hold),
        .rd_data (rd_data5),
        .rd_vld  (rd_vld5),
        .empty   (empty5),
        .level   (level5),
        .ovf_err (ovf_err5),
        .udf_err (udf_err5)
`ifdef JBI_MIN_RQ_HDR_FIFO_PAR_EN
        ,
        .par_err (par_err5)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the models by the FIFO rules, then step past the edge.
    task automatic applyStimulus(input logic we, input logic [63:0] wd, input logic re, input logic ho);
        int sz;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        hold    = ho;
        for (int k = 0; k < 2; k++) begin
            sz = (k == 0) ? q16.size() : q5.size();
            exp_ovf[k] = we && (sz == DEP[k]);
            exp_udf[k] = re && (sz == 0) && !ho;
            if (re && sz > 0 && !ho) begin
                exp_vld[k] = 1'b1;
                if (k == 0) exp_data[k] = q16.pop_front();
                else        exp_data[k] = q5.pop_front();
            end else if (!ho) begin
                exp_vld[k] = 1'b0;
            end
            if (we && sz < DEP[k]) begin
                if (k == 0) q16.push_back(wd);
                else        q5.push_back(wd);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Compare every output of both instances with the model.
    task automatic checkOutput();
        int sz;
        sz = q16.size();
        chk("vld16",   {63'd0, rd_vld},  {63'd0, exp_vld[0]});
        chk("data16",  rd_data,          exp_data[0]);
        chk("level16", {59'd0, level},   64'(sz));
        chk("empty16", {63'd0, empty},   {63'd0, sz == 0});
        chk("full16",  {63'd0, full},    {63'd0, sz == DEP[0]});
        chk("afull16", {63'd0, afull},   {63'd0, sz >= THRESH[0]});
        chk("ovf16",   {63'd0, ovf_err}, {63'd0, exp_ovf[0]});
        chk("udf16",   {63'd0, udf_err}, {63'd0, exp_udf[0]});
        sz = q5.size();
        chk("vld5",    {63'd0, rd_vld5},  {63'd0, exp_vld[1]});
        chk("data5",   rd_data5,          exp_data[1]);
        chk("level5",  {60'd0, level5},   64'(sz));
        chk("empty5",  {63'd0, empty5},   {63'd0, sz == 0});
        chk("full5",   {63'd0, full5},    {63'd0, sz == DEP[1]});
        chk("afull5",  {63'd0, afull5},   {63'd0, sz >= THRESH[1]});
        chk("ovf5",    {63'd0, ovf_err5}, {63'd0, exp_ovf[1]});
        chk("udf5",    {63'd0, udf_err5}, {63'd0, exp_udf[1]});
`ifdef JBI_MIN_RQ_HDR_FIFO_PAR_EN
        chk("par16",   {63'd0, par_err},  64'd0);
        chk("par5",    {63'd0, par_err5}, 64'd0);
`endif
    endtask

    task automatic step(input logic we, input logic [63:0] wd, input logic re, input logic ho);
        applyStimulus(we, wd, re, ho);
        checkOutput();
    endtask

    task automatic clearModel();
        q16.delete();
        q5.delete();
        for (int k = 0; k < 2; k++) begin
            exp_vld[k]  = 1'b0;
            exp_data[k] = '0;
            exp_ovf[k]  = 1'b0;
            exp_udf[k]  = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        // Push A,B,C then pop three back-to-back; hand-derived DEPTH=16 expectations.
        tbl[0] = '{1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 64'h0, 1};
        tbl[1] = '{1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 64'h0, 2};
        tbl[2] = '{1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 64'h0, 3};
        tbl[3] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'hA, 2};
        tbl[4] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'hB, 1};
        tbl[5] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'hC, 0};
        tbl[6] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'hC, 0};

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        hold    = 1'b0;
        clearModel();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].ho);
            checkOutput();
            chk("tbl_vld",   {63'd0, rd_vld}, {63'd0, tbl[i].ev});
            chk("tbl_data",  rd_data,         tbl[i].ed);
            chk("tbl_level", {59'd0, level},  64'(tbl[i].el));
        end

        // Fill to DEPTH=16, then one extra push must be refused.
        for (int i = 0; i < 16; i++) step(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
        chk("fill_full",  {63'd0, full},  64'd1);
        chk("fill_level", {59'd0, level}, 64'd16);
        step(1'b1, 64'hBAD, 1'b0, 1'b0);
        chk("ovf_pulse", {63'd0, ovf_err}, 64'd1);
        chk("ovf_level", {59'd0, level},   64'd16);
        step(1'b0, 64'h0, 1'b0, 1'b0);
        chk("ovf_single", {63'd0, ovf_err}, 64'd0);

        // Push and pop together while full: pop wins, push is refused.
        step(1'b1, 64'hDEAD, 1'b1, 1'b0);
        chk("fullpp_data",  rd_data,          64'h100);
        chk("fullpp_ovf",   {63'd0, ovf_err}, 64'd1);
        chk("fullpp_level", {59'd0, level},   64'd15);
        for (int i = 0; i < 16; i++) step(1'b0, 64'h0, 1'b1, 1'b0);

        // Push and pop together while empty: no bypass.
        step(1'b1, 64'h55, 1'b1, 1'b0);
        chk("emptypp_udf", {63'd0, udf_err}, 64'd1);
        chk("emptypp_vld", {63'd0, rd_vld},  64'd0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("emptypp_data", rd_data, 64'h55);

        // Streaming pairs wrap the DEPTH=5 pointers several times.
        step(1'b1, 64'h1FF, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 64'h200 + 64'(i), 1'b1, 1'b0);
        chk("wrap_data5", rd_data5, 64'h20A);

        // Hold for three cycles: read side frozen, pushes still land.
        for (int i = 0; i < 3; i++) step(1'b1, 64'h300 + 64'(i), 1'b1, 1'b1);
        chk("hold_data",  rd_data,         64'h20A);
        chk("hold_vld",   {63'd0, rd_vld}, 64'd1);
        chk("hold_level", {60'd0, level5}, 64'd4);
        for (int i = 0; i < 6; i++) step(1'b0, 64'h0, 1'b1, 1'b0);

        // Randomised traffic against the models.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 6), {$urandom, $urandom},
                 ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 2));
        end
        for (int i = 0; i < 18; i++) step(1'b0, 64'h0, 1'b1, 1'b0);

        // Reset landing between edges during an active pop.
        step(1'b1, 64'h77, 1'b0, 1'b0);
        step(1'b1, 64'h88, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("prerst_vld", {63'd0, rd_vld}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_vld",    {63'd0, rd_vld},  64'd0);
        chk("rst_level",  {59'd0, level},   64'd0);
        chk("rst_empty",  {63'd0, empty},   64'd1);
        chk("rst_data",   rd_data,          64'd0);
        chk("rst_level5", {60'd0, level5},  64'd0);
        clearModel();
        #2;
        rst = 1'b0;
        step(1'b0, 64'h0, 1'b1, 1'b0);
        step(1'b1, 64'h99, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        chk("postrst_data", rd_data, 64'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
